// File: rtl/store_buffer_unit.sv
// Store unit with a DEPTH-entry write buffer: formats SB/SH/SW/SD data onto byte lanes and drains to memory over req/ack.
// Optional: define STORE_MISALIGN_EXC_EN to reject misaligned stores with a one-cycle misaligned_o pulse.

module store_lane_fmt #(
  parameter int XLEN = 32,
  parameter int LANE = 0,
  localparam int NB = XLEN / 8,
  localparam int LW = $clog2(NB)
) (
  input  logic [LW-1:0]   off,
  input  logic [1:0]      size,
  input  logic [XLEN-1:0] rs2,
  output logic [7:0]      data,
  output logic            en
);
  logic [LW-1:0] lane_idx, low_mask, byte_idx;

  // A lane is selected when its upper index bits match the (size-aligned) offset;
  // the low bits pick which byte of the right-justified source lands here.
  always_comb begin
    lane_idx = LW'(LANE);
    low_mask = ~({LW{1'b1}} << size);
    en       = (lane_idx & ~low_mask) == (off & ~low_mask);
    byte_idx = lane_idx & low_mask;
    data     = en ? rs2[{byte_idx, 3'b000} +: 8] : 8'h00;
  end
endmodule

module store_buffer_unit #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  localparam int NB = XLEN / 8,
  localparam int LW = $clog2(NB),
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [2:0]      fun_3_in,
  input  logic [31:0]     iadder_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic            mem_wr_req_in,
  output logic            st_ready_o,
  output logic [31:0]     dm_addr_o,
  output logic [XLEN-1:0] dm_data_o,
  output logic [NB-1:0]   dm_wr_mask_o,
  output logic            dm_wr_req_o,
  input  logic            dm_ack_in,
  output logic            sb_empty_o,
  output logic [CW-1:0]   sb_count_o,
  output logic            misaligned_o
);
  logic [LW-1:0]         off;
  logic [1:0]            size;
  logic [NB-1:0][7:0]    fmt_data;
  logic [NB-1:0]         fmt_mask;
  logic [31:0]           fmt_addr;
  logic                  push, pop;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic [31:0]           mem_addr [DEPTH];
  logic [XLEN-1:0]       mem_data [DEPTH];
  logic [NB-1:0]         mem_mask [DEPTH];
  logic                  unused_ok;

  assign unused_ok = fun_3_in[2];
  assign off       = iadder_in[LW-1:0];
  // On a 32-bit datapath the SD encoding collapses to SW.
  assign size      = (XLEN == 32 && fun_3_in[1:0] == 2'b11) ? 2'b10 : fun_3_in[1:0];
  assign fmt_addr  = {iadder_in[31:LW], {LW{1'b0}}};

  for (genvar g = 0; g < NB; g++) begin : g_lane
    store_lane_fmt #(.XLEN(XLEN), .LANE(g)) u_lane (
      .off  (off),
      .size (size),
      .rs2  (rs2_in),
      .data (fmt_data[g]),
      .en   (fmt_mask[g])
    );
  end

  assign st_ready_o = (count != CW'(DEPTH));
  assign pop        = dm_ack_in && (count != '0);

`ifdef STORE_MISALIGN_EXC_EN
  logic misal, misal_q;
  assign misal = |(off & ~({LW{1'b1}} << size));
  assign push  = mem_wr_req_in && st_ready_o && !misal;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) misal_q <= 1'b0;
    else        misal_q <= mem_wr_req_in && st_ready_o && misal;
  end
  assign misaligned_o = misal_q;
`else
  assign push         = mem_wr_req_in && st_ready_o;
  assign misaligned_o = 1'b0;
`endif

  // Entry storage needs no reset: reads are masked whenever the buffer is empty.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_addr[wr_ptr] <= fmt_addr;
      mem_data[wr_ptr] <= fmt_data;
      mem_mask[wr_ptr] <= fmt_mask;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign sb_count_o   = count;
  assign sb_empty_o   = (count == '0);
  assign dm_wr_req_o  = !sb_empty_o;
  assign dm_addr_o    = dm_wr_req_o ? mem_addr[rd_ptr] : '0;
  assign dm_data_o    = dm_wr_req_o ? mem_data[rd_ptr] : '0;
  assign dm_wr_mask_o = dm_wr_req_o ? mem_mask[rd_ptr] : '0;
endmodule

// File: tb/tb_store_buffer_unit.sv
// Directed bench for store_buffer_unit (XLEN=32, DEPTH=4): lane-format table plus full/wrap/reset sequences.
module tb_store_buffer_unit;
  logic        clk_in = 0;
  logic        rst_in;
  logic [2:0]  fun_3_in;
  logic [31:0] iadder_in;
  logic [31:0] rs2_in;
  logic        mem_wr_req_in;
  logic        st_ready_o;
  logic [31:0] dm_addr_o;
  logic [31:0] dm_data_o;
  logic [3:0]  dm_wr_mask_o;
  logic        dm_wr_req_o;
  logic        dm_ack_in;
  logic        sb_empty_o;
  logic [2:0]  sb_count_o;
  logic        misaligned_o;

  int checks = 0;
  int errors = 0;

  store_buffer_unit #(.XLEN(32), .DEPTH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .fun_3_in(fun_3_in), .iadder_in(iadder_in),
    .rs2_in(rs2_in), .mem_wr_req_in(mem_wr_req_in), .st_ready_o(st_ready_o),
    .dm_addr_o(dm_addr_o), .dm_data_o(dm_data_o), .dm_wr_mask_o(dm_wr_mask_o),
    .dm_wr_req_o(dm_wr_req_o), .dm_ack_in(dm_ack_in), .sb_empty_o(sb_empty_o),
    .sb_count_o(sb_count_o), .misaligned_o(misaligned_o)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [3:0]  exp_mask;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_in);
  endtask

  task automatic drive_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    fun_3_in = f3; iadder_in = a; rs2_in = d; mem_wr_req_in = 1;
  endtask

  logic [31:0] model_q[$];
  logic [31:0] exp_head;

  initial begin
    vecs[0] = '{"sb_1003",   3'b000, 32'h1003, 32'h11223344, 32'h1000, 32'h44000000, 4'b1000};
    vecs[1] = '{"sh_2002",   3'b001, 32'h2002, 32'hAABBCCDD, 32'h2000, 32'hCCDD0000, 4'b1100};
    vecs[2] = '{"sb_1000",   3'b000, 32'h1000, 32'h123456AB, 32'h1000, 32'h000000AB, 4'b0001};
    vecs[3] = '{"sb_1001",   3'b000, 32'h1001, 32'h000000FF, 32'h1000, 32'h0000FF00, 4'b0010};
    vecs[4] = '{"sh_2000",   3'b001, 32'h2000, 32'h1234ABCD, 32'h2000, 32'h0000ABCD, 4'b0011};
    vecs[5] = '{"sw_2004",   3'b010, 32'h2004, 32'hDEADBEEF, 32'h2004, 32'hDEADBEEF, 4'b1111};
    vecs[6] = '{"sd_as_sw",  3'b111, 32'h2008, 32'hCAFEF00D, 32'h2008, 32'hCAFEF00D, 4'b1111};
    vecs[7] = '{"sb_f3bit2", 3'b100, 32'h300A, 32'h0000005A, 32'h3008, 32'h005A0000, 4'b0100};

    rst_in = 1; fun_3_in = 0; iadder_in = 0; rs2_in = 0; mem_wr_req_in = 0; dm_ack_in = 0;
    step();
    check("rst_req",   dm_wr_req_o, 0);
    check("rst_empty", sb_empty_o, 1);
    check("rst_ready", st_ready_o, 1);
    check("rst_count", sb_count_o, 0);
    check("rst_addr",  dm_addr_o, 0);
    check("rst_data",  dm_data_o, 0);
    check("rst_mask",  dm_wr_mask_o, 0);
    check("rst_misal", misaligned_o, 0);
    rst_in = 0;
    step();

    // Lane formatting table: enqueue into empty buffer, observe head next cycle, ack it.
    for (int i = 0; i < 8; i++) begin
      drive_req(vecs[i].f3, vecs[i].addr, vecs[i].data);
      step();
      mem_wr_req_in = 0;
      check({vecs[i].name, "_req"},  dm_wr_req_o, 1);
      check({vecs[i].name, "_addr"}, dm_addr_o, vecs[i].exp_addr);
      check({vecs[i].name, "_data"}, dm_data_o, vecs[i].exp_data);
      check({vecs[i].name, "_mask"}, dm_wr_mask_o, vecs[i].exp_mask);
      check({vecs[i].name, "_cnt"},  sb_count_o, 1);
      dm_ack_in = 1;
      step();
      dm_ack_in = 0;
      check({vecs[i].name, "_empty"}, sb_empty_o, 1);
      check({vecs[i].name, "_zdata"}, dm_data_o, 0);
    end

    // Ack while empty must be ignored.
    dm_ack_in = 1;
    step();
    dm_ack_in = 0;
    check("ack_empty_cnt", sb_count_o, 0);

    // Misaligned SW.
    drive_req(3'b010, 32'h3001, 32'h01020304);
    step();
    mem_wr_req_in = 0;
`ifdef STORE_MISALIGN_EXC_EN
    check("misal_pulse", misaligned_o, 1);
    check("misal_cnt",   sb_count_o, 0);
    check("misal_ready", st_ready_o, 1);
    step();
    check("misal_fall",  misaligned_o, 0);
`else
    check("misal_flag", misaligned_o, 0);
    check("misal_addr", dm_addr_o, 32'h3000);
    check("misal_mask", dm_wr_mask_o, 4'b1111);
    check("misal_data", dm_data_o, 32'h01020304);
    dm_ack_in = 1;
    step();
    dm_ack_in = 0;
`endif

    // Full buffer: five SW, fifth refused.
    for (int i = 1; i <= 5; i++) begin
      drive_req(3'b010, 32'h100 + 32'(i * 4), 32'(i));
      step();
    end
    mem_wr_req_in = 0;
    check("full_cnt",   sb_count_o, 4);
    check("full_ready", st_ready_o, 0);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain_%0d", i), dm_data_o, 32'(i));
      dm_ack_in = 1;
      step();
      if (i == 1) check("ready_after_ack", st_ready_o, 1);
    end
    dm_ack_in = 0;
    check("drain_empty", sb_empty_o, 1);

    // Simultaneous push/pop at count=2, enough cycles to wrap pointers.
    model_q.delete();
    for (int i = 0; i < 2; i++) begin
      drive_req(3'b010, 32'h200, 32'h10 + 32'(i));
      model_q.push_back(32'h10 + 32'(i));
      step();
    end
    for (int k = 0; k < 6; k++) begin
      exp_head = model_q.pop_front();
      check($sformatf("pp_head_%0d", k), dm_data_o, exp_head);
      check($sformatf("pp_cnt_%0d", k), sb_count_o, 2);
      drive_req(3'b010, 32'h200, 32'h12 + 32'(k));
      model_q.push_back(32'h12 + 32'(k));
      dm_ack_in = 1;
      step();
    end
    mem_wr_req_in = 0;
    check("pp_cnt_end", sb_count_o, 2);
    for (int k = 0; k < 2; k++) begin
      exp_head = model_q.pop_front();
      check($sformatf("pp_tail_%0d", k), dm_data_o, exp_head);
      step();
    end
    dm_ack_in = 0;
    check("pp_empty", sb_empty_o, 1);

    // Async reset with three pending entries.
    for (int i = 0; i < 3; i++) begin
      drive_req(3'b010, 32'h400, 32'hA0 + 32'(i));
      step();
    end
    mem_wr_req_in = 0;
    check("pre_rst_cnt", sb_count_o, 3);
    check("pre_rst_req", dm_wr_req_o, 1);
    #2 rst_in = 1;
    #1;
    check("async_rst_req", dm_wr_req_o, 0);
    check("async_rst_cnt", sb_count_o, 0);
    step();
    rst_in = 0;
    step();
    check("post_rst_req",  dm_wr_req_o, 0);
    check("post_rst_data", dm_data_o, 0);
    step();
    check("post_rst_cnt",  sb_count_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_buffer_unit.md
Name: store_buffer_unit

Overview:
Parametrised store unit with a write buffer, sitting between the execute-stage address adder and the data-memory port. It accepts store requests (SB/SH/SW, plus SD when XLEN=64) and formats data and byte-enables onto the correct lanes. Formatted entries queue in a DEPTH-entry FIFO, which drains to data memory over a req/ack handshake, so the pipeline does not stall on slow memory until the buffer is full.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
DEPTH, 4, buffer entries; power of two, >= 2.

Ports:
clk_in  input  1  clock; all state updates on rising edge.
rst_in  input  1  asynchronous, active-high reset.
fun_3_in  input  3  store funct3; bits [1:0] used: 00 SB, 01 SH, 10 SW, 11 SD (XLEN=64) / SW (XLEN=32); bit 2 ignored.
iadder_in  input  32  byte address of the store.
rs2_in  input  XLEN  store data, right-justified.
mem_wr_req_in  input  1  store request from pipeline.
st_ready_o  output  1  buffer can accept a request this cycle.
dm_addr_o  output  32  head-entry address, aligned to XLEN/8 bytes.
dm_data_o  output  XLEN  head-entry lane-formatted data.
dm_wr_mask_o  output  XLEN/8  head-entry byte enables.
dm_wr_req_o  output  1  head entry valid, write request to memory.
dm_ack_in  input  1  memory accepted the current head entry.
sb_empty_o  output  1  buffer empty.
sb_count_o  output  $clog2(DEPTH)+1  occupied entries.
misaligned_o  output  1  misaligned store rejected; see Optional Feature.

Behaviour:
- Reset (async, immediate): pointers and count cleared. dm_wr_req_o=0, dm_addr_o=0, dm_data_o=0, dm_wr_mask_o=0, sb_count_o=0, sb_empty_o=1, st_ready_o=1, misaligned_o=0. Reset during a pending handshake discards all entries; dm_wr_req_o falls without waiting for a clock.
- Enqueue: happens when mem_wr_req_in && st_ready_o at the clock edge.
- Ready: st_ready_o = (count != DEPTH). There is no combinational path from dm_ack_in to st_ready_o, so a full buffer refuses a request even in a cycle where it is popping.
- Lane formatting at enqueue, with off = iadder_in[$clog2(XLEN/8)-1:0]:
  - SB: rs2[7:0] placed in byte lane off; mask bit off set.
  - SH: rs2[15:0] placed in lanes {off[hi:1],0} and +1.
  - SW: rs2[31:0] placed in word lane; 4 mask bits set.
  - SD: all lanes; all mask bits set.
  - Unselected data lanes are 0.
  - Stored address = iadder_in with the low $clog2(XLEN/8) bits cleared.
- Drain: when count>0, head entry is driven on dm_*, with dm_wr_req_o=1. dm_* holds stable until dm_ack_in=1 at a clock edge, which pops the head. The next entry, if any, appears the following cycle, so back-to-back acks drain one entry per cycle. dm_ack_in is ignored while empty.
- Empty: dm_wr_req_o=0, and dm_addr_o, dm_data_o and dm_wr_mask_o read 0.
- Latency: request enqueued into an empty buffer at edge N is visible on dm_* after edge N (1 cycle).
- Simultaneous enqueue and pop: count unchanged, FIFO order preserved. Pointers wrap modulo DEPTH.
- Misalignment definition: SH with off[0]=1; SW with off[1:0]!=0; SD with off[2:0]!=0.

Optional Feature:
Macro STORE_MISALIGN_EXC_EN.
- Defined: a misaligned request is not enqueued. misaligned_o pulses high for exactly one cycle after the request edge. Count and dm_* are unaffected, and st_ready_o is unaffected.
- Undefined: the offending low address bits are treated as 0 (SW to 0x3001 behaves as SW to 0x3000), the request is enqueued normally, and misaligned_o is tied 0.

Test Plan:
1. XLEN=32, SB iadder=0x1003, rs2=0x11223344 -> next cycle: dm_addr_o=0x1000, dm_data_o=0x44000000, dm_wr_mask_o=4'b1000, dm_wr_req_o=1. Assert dm_ack_in -> sb_empty_o=1.
2. SH iadder=0x2002, rs2=0xAABBCCDD -> dm_data_o=0xCCDD0000, dm_wr_mask_o=4'b1100. XLEN=64 SB iadder=0x4005, rs2=0xEE -> dm_addr_o=0x4000, data 0x0000EE0000000000, mask 8'b00100000.
3. DEPTH=4, dm_ack_in=0, five consecutive SW (data 1..5) -> sb_count_o=4, st_ready_o=0, 5th not stored. One ack -> st_ready_o=1 next cycle. Drained data order is 1,2,3,4.
4. count=2, enqueue and ack in the same cycle -> count stays 2; popped entry is the oldest; pointer wrap after 6 such cycles is correct.
5. SW iadder=0x3001: with STORE_MISALIGN_EXC_EN -> misaligned_o=1 for one cycle, count unchanged. Without it -> entry addr 0x3000, mask 4'b1111.
6. count=3 with dm_wr_req_o=1 and no ack, assert rst_in mid-cycle -> dm_wr_req_o=0 before the next edge, sb_count_o=0, and no stale entry appears after release.
